// File: rtl/cf_fft_r2sdf_stage.sv
// ---------------------------------------------------------------------------
// cf_fft_r2sdf_stage
//   One radix-2 single-path delay-feedback (R2SDF) butterfly stage.
//   Frames are 2*D samples long (D = 2^LOG_D).
//   - First half of a frame: the input is parked in the feedback FIFO and the
//     FIFO output (differences from the previous frame) is sent out.
//   - Second half: the FIFO output a is combined with the input b.
//     a+b goes out and a-b goes back into the FIFO.
//   Both butterfly results are either halved (scale_en=1) or saturated to WIDTH.
//
// Ports
//   clock_c             rising-edge clock
//   reset_c             asynchronous active-high reset (the FIFO RAM is not reset)
//   enable              clock enable; all state, FIFO included, holds when low
//   sync_in             current input sample is frame index 0
//   din_re / din_im     two's-complement input sample
//   scale_en            1: divide butterfly results by 2, 0: saturate
//   sync_out            output sample is sum index 0
//   valid_out           output stream is frame aligned
//   dout_re / dout_im   registered output sample
//   ovf                 sticky saturation flag, restarted at each sync_out
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge where enable=1, and the outputs change only on such edges.
// valid_out qualifies the whole output stream, not individual samples.
// ---------------------------------------------------------------------------
module cf_fft_r2sdf_stage #(
    parameter int WIDTH = 16,
    parameter int LOG_D = 9
) (
    input  logic                    clock_c,
    input  logic                    reset_c,
    input  logic                    enable,
    input  logic                    sync_in,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    input  logic                    scale_en,
    output logic                    sync_out,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] dout_re,
    output logic signed [WIDTH-1:0] dout_im,
    output logic                    ovf
);

    localparam int CW = LOG_D + 1;
    localparam int D  = 1 << LOG_D;

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        idx;
    logic                 locked;     // a sync_in has been seen since reset
    logic [LOG_D-1:0]     addr;
    logic [2*WIDTH-1:0]   fifo_mem [D];
    logic [2*WIDTH-1:0]   fifo_rd;
    logic [2*WIDTH-1:0]   fifo_wr;

    logic signed [WIDTH-1:0] a_re, a_im;
    logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
    logic [WIDTH:0]          f_sum_re, f_sum_im, f_dif_re, f_dif_im;
    logic signed [WIDTH-1:0] cand_re, cand_im;
    logic                    sat_any;
    logic                    frame_hit;

    // Reduce a WIDTH+1 bit result to WIDTH bits.
    // The return value is {saturated, value}.
    function automatic logic [WIDTH:0] fit(input logic signed [WIDTH:0] s,
                                           input logic sc);
        logic [WIDTH:0] r;
        r = {1'b0, s[WIDTH:1]};                      // floor(s/2)
        if (!sc) begin
            if (s[WIDTH] != s[WIDTH-1])
                r = {1'b1, s[WIDTH], {(WIDTH-1){~s[WIDTH]}}};
            else
                r = {1'b0, s[WIDTH-1:0]};
        end
        return r;
    endfunction

    // A sync sample is index 0 whatever the counter says.
    assign idx  = sync_in ? '0 : cnt;
    // The RAM is addressed by the position within the half frame.
    // Entry k is written at index k and read back at index k+D.
    // That gives exactly D enabled cycles of delay inside a frame,
    // including a frame that starts with a resync.
    assign addr    = idx[LOG_D-1:0];
    assign fifo_rd = fifo_mem[addr];

    always_comb begin
        a_re      = fifo_rd[2*WIDTH-1:WIDTH];
        a_im      = fifo_rd[WIDTH-1:0];
        sum_re    = {a_re[WIDTH-1], a_re} + {din_re[WIDTH-1], din_re};
        sum_im    = {a_im[WIDTH-1], a_im} + {din_im[WIDTH-1], din_im};
        dif_re    = {a_re[WIDTH-1], a_re} - {din_re[WIDTH-1], din_re};
        dif_im    = {a_im[WIDTH-1], a_im} - {din_im[WIDTH-1], din_im};
        f_sum_re  = fit(sum_re, scale_en);
        f_sum_im  = fit(sum_im, scale_en);
        f_dif_re  = fit(dif_re, scale_en);
        f_dif_im  = fit(dif_im, scale_en);

        // First half of the frame: park the input and emit the FIFO contents.
        cand_re   = a_re;
        cand_im   = a_im;
        fifo_wr   = {din_re, din_im};
        sat_any   = 1'b0;
        if (idx[LOG_D]) begin
            cand_re = f_sum_re[WIDTH-1:0];
            cand_im = f_sum_im[WIDTH-1:0];
            fifo_wr = {f_dif_re[WIDTH-1:0], f_dif_im[WIDTH-1:0]};
            sat_any = f_sum_re[WIDTH] | f_sum_im[WIDTH] |
                      f_dif_re[WIDTH] | f_dif_im[WIDTH];
        end
        // This cycle computes sum index 0 of a frame that has been synced.
        frame_hit = locked && (idx == CW'(D));
    end

    always_ff @(posedge clock_c) begin
        if (enable)
            fifo_mem[addr] <= fifo_wr;
    end

    always_ff @(posedge clock_c or posedge reset_c) begin
        if (reset_c) begin
            cnt       <= '0;
            locked    <= 1'b0;
            dout_re   <= '0;
            dout_im   <= '0;
            sync_out  <= 1'b0;
            valid_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (enable) begin
            cnt      <= idx + CW'(1);
            dout_re  <= cand_re;
            dout_im  <= cand_im;
            sync_out <= frame_hit;
            if (sync_in)
                locked <= 1'b1;
            // frame_hit needs idx=D, so it cannot coincide with sync_in.
            if (frame_hit)
                valid_out <= 1'b1;
            else if (sync_in && (cnt != '0))
                valid_out <= 1'b0;
            // A new frame restarts the flag but keeps its own sum-0 saturation.
            ovf <= frame_hit ? sat_any : (ovf | sat_any);
        end
    end

endmodule
